// File: rtl/l1_d_controller.sv
// -----------------------------------------------------------------------------
// l1_d_controller
//   Control path of a 2-way set-associative, write-back, write-allocate L1 data
//   cache. It holds the tag store (valid/dirty/tag per way, one LRU bit per
//   set), decides hit/miss for the CPU request, selects a victim on a miss,
//   writes a dirty victim back to L2, fetches the requested line from L2 and
//   drives the strobes that steer the separate data array.
//
//   Geometry: 32 sets x 2 ways, 64-byte lines.
//     address tag = [31:11], index = [10:6], offset = [5:0]
//
// Ports
//   clk            in   clock, rising edge
//   nrst           in   asynchronous active-low reset
//   read_C_L1      in   CPU load request (held while stalled)
//   write_C_L1     in   CPU store request (wins over read when both set)
//   address_C_L1   in   CPU byte address [31:0]
//   ready_L2_L1    in   L2 finished the current line read/write
//   stall_L1_C     out  CPU must hold its request (combinational)
//   index_L1       out  set index to data array
//   offset_L1      out  byte offset to data array
//   way            out  way selected in the data array
//   update         out  store-hit word write strobe to data array
//   refill         out  line refill strobe to data array
//   read_L1_L2     out  line fetch request to L2 (held until ready)
//   write_L1_L2    out  dirty-line writeback request to L2 (held until ready)
//   address_L1_L2  out  line address to L2, [5:0] always zero
// -----------------------------------------------------------------------------
module l1_d_controller (
   input  logic        clk,
   input  logic        nrst,
   input  logic        read_C_L1,
   input  logic        write_C_L1,
   input  logic [31:0] address_C_L1,
   input  logic        ready_L2_L1,
   output logic        stall_L1_C,
   output logic [4:0]  index_L1,
   output logic [5:0]  offset_L1,
   output logic        way,
   output logic        update,
   output logic        refill,
   output logic        read_L1_L2,
   output logic        write_L1_L2,
   output logic [31:0] address_L1_L2
);

   typedef enum logic [1:0] {
      COMPARE   = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        victim_q, victim_d;

   // Tag store: per set, one bit per way for valid/dirty; LRU bit names the
   // least-recently-used way of the set.
   logic [1:0]  valid_q [32];
   logic [1:0]  dirty_q [32];
   logic [20:0] tag_q   [32][2];
   logic [31:0] lru_q;

   logic [20:0] req_tag;
   logic [4:0]  req_idx;
   logic        req_act;
   logic        hit0, hit1, hit, miss;
   logic        hit_way, victim_sel;

   assign req_tag   = address_C_L1[31:11];
   assign req_idx   = address_C_L1[10:6];
   assign index_L1  = req_idx;
   assign offset_L1 = address_C_L1[5:0];
   assign req_act   = read_C_L1 | write_C_L1;

   assign hit0    = valid_q[req_idx][0] && (tag_q[req_idx][0] == req_tag);
   assign hit1    = valid_q[req_idx][1] && (tag_q[req_idx][1] == req_tag);
   assign hit     = req_act && (state_q == COMPARE) && (hit0 || hit1);
   assign miss    = req_act && (state_q == COMPARE) && !(hit0 || hit1);
   assign hit_way = hit1 && !hit0;

   // Fill an invalid way first; only evict by LRU when the set is full.
   assign victim_sel = !valid_q[req_idx][0] ? 1'b0 :
                       !valid_q[req_idx][1] ? 1'b1 : lru_q[req_idx];

   // Outputs and next state. Everything is forced low while nrst is held so
   // that a reset in the middle of a transaction silences L2 and the CPU stall
   // immediately, not at the next clock.
   always_comb begin
      state_d       = state_q;
      victim_d      = victim_q;
      stall_L1_C    = 1'b0;
      way           = 1'b0;
      update        = 1'b0;
      refill        = 1'b0;
      read_L1_L2    = 1'b0;
      write_L1_L2   = 1'b0;
      address_L1_L2 = 32'd0;
      if (nrst) begin
         unique case (state_q)
            COMPARE: begin
               if (hit) begin
                  way    = hit_way;
                  update = write_C_L1;
               end else if (miss) begin
                  stall_L1_C = 1'b1;
                  victim_d   = victim_sel;
                  if (valid_q[req_idx][victim_sel] && dirty_q[req_idx][victim_sel])
                     state_d = WRITEBACK;
                  else
                     state_d = ALLOCATE;
               end
            end
            WRITEBACK: begin
               stall_L1_C    = 1'b1;
               write_L1_L2   = 1'b1;
               way           = victim_q;
               address_L1_L2 = {tag_q[req_idx][victim_q], req_idx, 6'b0};
               if (ready_L2_L1)
                  state_d = ALLOCATE;
            end
            ALLOCATE: begin
               stall_L1_C    = 1'b1;
               read_L1_L2    = 1'b1;
               way           = victim_q;
               address_L1_L2 = {req_tag, req_idx, 6'b0};
               if (ready_L2_L1) begin
                  refill  = 1'b1;
                  state_d = COMPARE;
               end
            end
            default: state_d = COMPARE;
         endcase
      end
   end

   // Control state plus valid/dirty/LRU bits; all cleared by reset.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= COMPARE;
         victim_q <= 1'b0;
         lru_q    <= 32'd0;
         for (int s = 0; s < 32; s++) begin
            valid_q[s] <= 2'b00;
            dirty_q[s] <= 2'b00;
         end
      end else begin
         state_q  <= state_d;
         victim_q <= victim_d;
         if (hit) begin
            lru_q[req_idx] <= ~hit_way;
            if (write_C_L1)
               dirty_q[req_idx][hit_way] <= 1'b1;
         end
         if (refill) begin
            valid_q[req_idx][victim_q] <= 1'b1;
            dirty_q[req_idx][victim_q] <= 1'b0;
         end
      end
   end

   // Stored tags carry no reset; they are qualified by the valid bits.
   always_ff @(posedge clk) begin
      if (refill)
         tag_q[req_idx][victim_q] <= req_tag;
   end

endmodule

// File: tb/tb_l1_d_controller.sv
// -----------------------------------------------------------------------------
// tb_l1_d_controller
//   Directed bench for the L1 data-cache controller. Inputs change 2 time
//   units after each rising edge; outputs are sampled 1 unit later, well
//   away from the next edge.
// -----------------------------------------------------------------------------
module tb_l1_d_controller;

   logic        clk = 1'b0;
   logic        nrst;
   logic        read_C_L1;
   logic        write_C_L1;
   logic [31:0] address_C_L1;
   logic        ready_L2_L1;
   logic        stall_L1_C;
   logic [4:0]  index_L1;
   logic [5:0]  offset_L1;
   logic        way;
   logic        update;
   logic        refill;
   logic        read_L1_L2;
   logic        write_L1_L2;
   logic [31:0] address_L1_L2;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   l1_d_controller dut (
      .clk           (clk),
      .nrst          (nrst),
      .read_C_L1     (read_C_L1),
      .write_C_L1    (write_C_L1),
      .address_C_L1  (address_C_L1),
      .ready_L2_L1   (ready_L2_L1),
      .stall_L1_C    (stall_L1_C),
      .index_L1      (index_L1),
      .offset_L1     (offset_L1),
      .way           (way),
      .update        (update),
      .refill        (refill),
      .read_L1_L2    (read_L1_L2),
      .write_L1_L2   (write_L1_L2),
      .address_L1_L2 (address_L1_L2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic req(input logic rd, input logic wr, input logic [31:0] a);
      read_C_L1    = rd;
      write_C_L1   = wr;
      address_C_L1 = a;
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk_quiet_outputs(input string tag);
      chk({tag, "_stall"}, 32'(stall_L1_C), 32'd0);
      chk({tag, "_rd"},    32'(read_L1_L2), 32'd0);
      chk({tag, "_wr"},    32'(write_L1_L2), 32'd0);
      chk({tag, "_refill"},32'(refill), 32'd0);
      chk({tag, "_update"},32'(update), 32'd0);
      chk({tag, "_way"},   32'(way), 32'd0);
      chk({tag, "_addr"},  address_L1_L2, 32'd0);
   endtask

   initial begin
      nrst = 1'b0;
      read_C_L1 = 1'b0; write_C_L1 = 1'b0; address_C_L1 = 32'd0; ready_L2_L1 = 1'b0;

      // Reset with a live request: everything must stay quiet.
      #3;
      req(1'b1, 1'b0, 32'h0000_0840);
      chk_quiet_outputs("rst");
      tick();
      nrst = 1'b1;
      req(1'b0, 1'b0, 32'd0);
      chk("idle_stall", 32'(stall_L1_C), 32'd0);
      tick();

      // Cold load 0x840: miss -> ALLOCATE -> refill way 0 -> hit.
      req(1'b1, 1'b0, 32'h0000_0840);
      chk("cold_miss_stall", 32'(stall_L1_C), 32'd1);
      chk("cold_miss_rd", 32'(read_L1_L2), 32'd0);
      tick(); settle();
      chk("cold_alloc_rd", 32'(read_L1_L2), 32'd1);
      chk("cold_alloc_wr", 32'(write_L1_L2), 32'd0);
      chk("cold_alloc_addr", address_L1_L2, 32'h0000_0840);
      chk("cold_alloc_way", 32'(way), 32'd0);
      chk("cold_alloc_norefill", 32'(refill), 32'd0);
      ready_L2_L1 = 1'b1; settle();
      chk("cold_refill", 32'(refill), 32'd1);
      chk("cold_refill_stall", 32'(stall_L1_C), 32'd1);
      tick(); ready_L2_L1 = 1'b0; settle();
      chk("cold_hit_stall", 32'(stall_L1_C), 32'd0);
      chk("cold_hit_way", 32'(way), 32'd0);
      chk("cold_hit_update", 32'(update), 32'd0);
      chk("cold_hit_rd", 32'(read_L1_L2), 32'd0);
      tick();

      // Store hit 0x844: same-cycle update, makes way 0 of set 1 dirty.
      req(1'b0, 1'b1, 32'h0000_0844);
      chk("st_update", 32'(update), 32'd1);
      chk("st_offset", 32'(offset_L1), 32'h4);
      chk("st_index", 32'(index_L1), 32'h1);
      chk("st_stall", 32'(stall_L1_C), 32'd0);
      chk("st_way", 32'(way), 32'd0);
      tick();
      req(1'b0, 1'b0, 32'h0000_0844);
      chk("noreq_stall", 32'(stall_L1_C), 32'd0);
      chk("noreq_update", 32'(update), 32'd0);
      tick();

      // Fill way 1 of set 1 with tag 2 (clean victim: no writeback).
      req(1'b1, 1'b0, 32'h0000_1040);
      chk("w1_miss_stall", 32'(stall_L1_C), 32'd1);
      tick(); settle();
      chk("w1_alloc_rd", 32'(read_L1_L2), 32'd1);
      chk("w1_alloc_nowr", 32'(write_L1_L2), 32'd0);
      chk("w1_alloc_addr", address_L1_L2, 32'h0000_1040);
      chk("w1_alloc_way", 32'(way), 32'd1);
      ready_L2_L1 = 1'b1; settle();
      chk("w1_refill", 32'(refill), 32'd1);
      tick(); ready_L2_L1 = 1'b0; settle();
      chk("w1_hit_stall", 32'(stall_L1_C), 32'd0);
      chk("w1_hit_way", 32'(way), 32'd1);
      tick();

      // Load tag 3: way 0 is LRU and dirty -> WRITEBACK of 0x840, then fetch 0x1840.
      req(1'b1, 1'b0, 32'h0000_1840);
      chk("dv_miss_stall", 32'(stall_L1_C), 32'd1);
      tick(); settle();
      for (int i = 0; i < 10; i++) begin
         chk("wb_wr", 32'(write_L1_L2), 32'd1);
         chk("wb_stall", 32'(stall_L1_C), 32'd1);
         chk("wb_addr", address_L1_L2, 32'h0000_0840);
         if (i == 0) begin
            chk("wb_rd", 32'(read_L1_L2), 32'd0);
            chk("wb_way", 32'(way), 32'd0);
            chk("wb_norefill", 32'(refill), 32'd0);
         end
         tick(); settle();
      end
      ready_L2_L1 = 1'b1; settle();
      chk("wb_ready_wr", 32'(write_L1_L2), 32'd1);
      chk("wb_ready_norefill", 32'(refill), 32'd0);
      tick(); ready_L2_L1 = 1'b0; settle();
      chk("dv_alloc_rd", 32'(read_L1_L2), 32'd1);
      chk("dv_alloc_wr", 32'(write_L1_L2), 32'd0);
      chk("dv_alloc_addr", address_L1_L2, 32'h0000_1840);
      chk("dv_alloc_way", 32'(way), 32'd0);
      ready_L2_L1 = 1'b1; settle();
      chk("dv_refill", 32'(refill), 32'd1);
      tick(); ready_L2_L1 = 1'b0; settle();
      chk("dv_hit_stall", 32'(stall_L1_C), 32'd0);
      chk("dv_hit_way", 32'(way), 32'd0);
      tick();

      // Tag 1 was evicted from way 0; tag 2 still in way 1.
      req(1'b1, 1'b0, 32'h0000_1040);
      chk("t2_still_hit", 32'(stall_L1_C), 32'd0);
      chk("t2_still_way", 32'(way), 32'd1);
      tick();

      // Miss to tag 4 (victim way 0, LRU after the tag-2 hit; clean), reset in ALLOCATE.
      req(1'b1, 1'b0, 32'h0000_2040);
      chk("t4_miss_stall", 32'(stall_L1_C), 32'd1);
      tick(); settle();
      chk("t4_alloc_rd", 32'(read_L1_L2), 32'd1);
      chk("t4_alloc_nowr", 32'(write_L1_L2), 32'd0);
      chk("t4_alloc_way", 32'(way), 32'd0);
      nrst = 1'b0; settle();
      chk_quiet_outputs("midrst");
      tick();
      nrst = 1'b1;
      req(1'b1, 1'b0, 32'h0000_1840);
      chk("post_rst_miss", 32'(stall_L1_C), 32'd1);
      tick(); settle();
      chk("post_rst_alloc_rd", 32'(read_L1_L2), 32'd1);
      chk("post_rst_alloc_wr", 32'(write_L1_L2), 32'd0);
      chk("post_rst_addr", address_L1_L2, 32'h0000_1840);
      chk("post_rst_way", 32'(way), 32'd0);
      ready_L2_L1 = 1'b1; settle();
      chk("post_rst_refill", 32'(refill), 32'd1);
      tick(); ready_L2_L1 = 1'b0;
      req(1'b0, 1'b0, 32'd0);
      chk("end_idle_stall", 32'(stall_L1_C), 32'd0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
